// File: rtl/hlsm_job_sequencer.sv
// Initiator for the HLSM Start/Done handshake: takes operand jobs, runs one HLSM,
// returns captured z/x (or a timeout abort) on a valid/ready result port.
module hlsm_job_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned MASK    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic signed [WIDTH-1:0] job_a,
  input  logic signed [WIDTH-1:0] job_b,
  input  logic signed [WIDTH-1:0] job_c,
  input  logic                    job_t,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_z,
  output logic [WIDTH-1:0]        res_x,
  output logic                    res_timeout,
  output logic                    hlsm_start,
  output logic                    hlsm_rst,
  output logic signed [WIDTH-1:0] hlsm_a,
  output logic signed [WIDTH-1:0] hlsm_b,
  output logic signed [WIDTH-1:0] hlsm_c,
  output logic [WIDTH-1:0]        hlsm_zero,
  output logic [WIDTH-1:0]        hlsm_one,
  output logic                    hlsm_t,
  input  logic                    hlsm_done,
  input  logic [WIDTH-1:0]        hlsm_z,
  input  logic [WIDTH-1:0]        hlsm_x,
  output logic                    busy,
  output logic [CNT_W-1:0]        job_count,
  output logic [CNT_W-1:0]        timeout_count
);

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            accept;
  logic            done_q;
  logic            timeout_hit;
  logic            tmo_pulse;

  // Done is masked for the first MASK RUN cycles so a stale Done from the prior job is ignored.
  assign accept      = (state == IDLE) & job_valid;
  assign done_q      = (state == RUN) & hlsm_done & (wait_cnt >= WC_W'(MASK));
  assign timeout_hit = (state == RUN) & ~done_q & (wait_cnt == WC_W'(TIMEOUT - 1));

  assign hlsm_zero = '0;
  assign hlsm_one  = WIDTH'(1);

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_valid) state_nxt = RUN;
      RUN:     if (done_q || timeout_hit) state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; Start drops in the very cycle Done qualifies so the HLSM never relaunches.
  always_comb begin
    job_ready  = 1'b0;
    busy       = 1'b1;
    hlsm_start = 1'b0;
    hlsm_rst   = Rst | tmo_pulse;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
      end
      RUN:     hlsm_start = ~done_q & ~Rst;
      default: ;
    endcase
  end

  // Datapath: operands, wait counter, result capture and statistics
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hlsm_a        <= '0;
      hlsm_b        <= '0;
      hlsm_c        <= '0;
      hlsm_t        <= 1'b0;
      wait_cnt      <= '0;
      tmo_pulse     <= 1'b0;
      res_valid     <= 1'b0;
      res_timeout   <= 1'b0;
      res_z         <= '0;
      res_x         <= '0;
      job_count     <= '0;
      timeout_count <= '0;
    end else begin
      tmo_pulse <= timeout_hit;
      if (accept) begin
        hlsm_a   <= job_a;
        hlsm_b   <= job_b;
        hlsm_c   <= job_c;
        hlsm_t   <= job_t;
        wait_cnt <= '0;
      end else if (state == RUN) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
      if (done_q) begin
        res_z       <= hlsm_z;
        res_x       <= hlsm_x;
        res_timeout <= 1'b0;
        res_valid   <= 1'b1;
        job_count   <= job_count + CNT_W'(1);
      end else if (timeout_hit) begin
        res_z         <= '0;
        res_x         <= '0;
        res_timeout   <= 1'b1;
        res_valid     <= 1'b1;
        timeout_count <= timeout_count + CNT_W'(1);
      end else if ((state == RESP) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// Directed bench for hlsm_job_sequencer; the bench plays the HLSM by driving Done/z/x by hand.
module tb_hlsm_job_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned MASK    = 2;
  localparam int unsigned CNT_W   = 2;

  logic                    Clk = 1'b0;
  logic                    Rst;
  logic                    job_valid;
  logic                    job_ready;
  logic signed [WIDTH-1:0] job_a, job_b, job_c;
  logic                    job_t;
  logic                    res_valid;
  logic                    res_ready;
  logic [WIDTH-1:0]        res_z, res_x;
  logic                    res_timeout;
  logic                    hlsm_start, hlsm_rst;
  logic signed [WIDTH-1:0] hlsm_a, hlsm_b, hlsm_c;
  logic [WIDTH-1:0]        hlsm_zero, hlsm_one;
  logic                    hlsm_t;
  logic                    hlsm_done;
  logic [WIDTH-1:0]        hlsm_z, hlsm_x;
  logic                    busy;
  logic [CNT_W-1:0]        job_count, timeout_count;

  int n_checks = 0;
  int n_errors = 0;

  hlsm_job_sequencer #(
    .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .MASK(MASK), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_t(job_t),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_x(res_x), .res_timeout(res_timeout),
    .hlsm_start(hlsm_start), .hlsm_rst(hlsm_rst),
    .hlsm_a(hlsm_a), .hlsm_b(hlsm_b), .hlsm_c(hlsm_c),
    .hlsm_zero(hlsm_zero), .hlsm_one(hlsm_one), .hlsm_t(hlsm_t),
    .hlsm_done(hlsm_done), .hlsm_z(hlsm_z), .hlsm_x(hlsm_x),
    .busy(busy), .job_count(job_count), .timeout_count(timeout_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Done is already held high: accept, three RUN cycles (Done qualifies at wait_cnt=2), then RESP.
  task automatic run_job(input logic [CNT_W-1:0] exp_cnt);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("wrap_valid", 32'(res_valid), 32'd1);
    chk("wrap_count", 32'(job_count), 32'(exp_cnt));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; job_valid = 1'b0; job_a = '0; job_b = '0; job_c = '0; job_t = 1'b0;
    res_ready = 1'b0; hlsm_done = 1'b0; hlsm_z = '0; hlsm_x = '0;
    tick();
    tick();
    chk("rst_hlsm_rst", 32'(hlsm_rst), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_start", 32'(hlsm_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_job_count", 32'(job_count), 32'd0);
    chk("rst_hlsm_a", hlsm_a, 32'd0);
    chk("const_zero", hlsm_zero, 32'd0);
    chk("const_one", hlsm_one, 32'd1);
    Rst = 1'b0;
    #1;
    chk("rst_release", 32'(hlsm_rst), 32'd0);
    chk("idle_ready", 32'(job_ready), 32'd1);

    // Job 1: Done arrives in RUN cycle 11
    job_a = 32'sd5; job_b = 32'sd7; job_c = 32'sd9; job_t = 1'b1; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    job_a = 32'sd77;
    #1;
    chk("j1_hlsm_a", hlsm_a, 32'd5);
    chk("j1_hlsm_b", hlsm_b, 32'd7);
    chk("j1_hlsm_c", hlsm_c, 32'd9);
    chk("j1_hlsm_t", 32'(hlsm_t), 32'd1);
    chk("j1_busy", 32'(busy), 32'd1);
    chk("j1_job_ready", 32'(job_ready), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      chk("j1_start_run", 32'(hlsm_start), 32'd1);
      chk("j1_no_result", 32'(res_valid), 32'd0);
      tick();
    end
    hlsm_done = 1'b1; hlsm_z = 32'd12; hlsm_x = 32'd3;
    #1;
    chk("j1_start_drop", 32'(hlsm_start), 32'd0);
    tick();
    chk("j1_res_valid", 32'(res_valid), 32'd1);
    chk("j1_res_z", res_z, 32'd12);
    chk("j1_res_x", res_x, 32'd3);
    chk("j1_timeout", 32'(res_timeout), 32'd0);
    chk("j1_count", 32'(job_count), 32'd1);
    chk("j1_resp_start", 32'(hlsm_start), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("j1_released", 32'(res_valid), 32'd0);
    chk("j1_idle_ready", 32'(job_ready), 32'd1);

    // Job 2: Done still high from job 1 must be masked for MASK cycles
    job_a = 32'sd1; job_b = 32'sd2; job_c = 32'sd3; job_t = 1'b0; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    #1;
    chk("j2_mask0_start", 32'(hlsm_start), 32'd1);
    tick();
    chk("j2_mask1_start", 32'(hlsm_start), 32'd1);
    chk("j2_mask1_valid", 32'(res_valid), 32'd0);
    tick();
    hlsm_z = 32'd100; hlsm_x = 32'd200;
    #1;
    chk("j2_qual_start", 32'(hlsm_start), 32'd0);
    chk("j2_qual_valid", 32'(res_valid), 32'd0);
    tick();
    chk("j2_res_valid", 32'(res_valid), 32'd1);
    chk("j2_res_z", res_z, 32'd100);
    chk("j2_res_x", res_x, 32'd200);
    chk("j2_count", 32'(job_count), 32'd2);

    // Backpressure: consumer stalls 10 cycles while inputs churn
    hlsm_done = 1'b0; hlsm_z = 32'hDEAD; hlsm_x = 32'hBEEF;
    job_a = 32'sd99; job_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_res_z", res_z, 32'd100);
      chk("bp_res_x", res_x, 32'd200);
      chk("bp_job_ready", 32'(job_ready), 32'd0);
      chk("bp_start", 32'(hlsm_start), 32'd0);
      chk("bp_hlsm_a", hlsm_a, 32'd1);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_released", 32'(res_valid), 32'd0);

    // Timeout: Done never comes, 16 RUN cycles then abort
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk("to_start", 32'(hlsm_start), 32'd1);
      chk("to_no_rst", 32'(hlsm_rst), 32'd0);
      tick();
    end
    chk("to_rst_pulse", 32'(hlsm_rst), 32'd1);
    chk("to_valid", 32'(res_valid), 32'd1);
    chk("to_flag", 32'(res_timeout), 32'd1);
    chk("to_res_z", res_z, 32'd0);
    chk("to_res_x", res_x, 32'd0);
    chk("to_count", 32'(timeout_count), 32'd1);
    chk("to_job_count", 32'(job_count), 32'd2);
    chk("to_start_off", 32'(hlsm_start), 32'd0);
    tick();
    chk("to_rst_end", 32'(hlsm_rst), 32'd0);
    chk("to_hold", 32'(res_timeout), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset during RUN cycle 4 drops the job
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    tick();
    Rst = 1'b1;
    #1;
    chk("mr_start_in_rst", 32'(hlsm_start), 32'd0);
    chk("mr_hlsm_rst", 32'(hlsm_rst), 32'd1);
    tick();
    Rst = 1'b0;
    #1;
    chk("mr_start", 32'(hlsm_start), 32'd0);
    chk("mr_valid", 32'(res_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_tcount", 32'(timeout_count), 32'd0);

    // Counter wrap with CNT_W=2: 1,2,3,0,1
    hlsm_done = 1'b1; hlsm_z = 32'd7; hlsm_x = 32'd8;
    run_job(2'd1);
    chk("mr_next_z", res_z, 32'd7);
    run_job(2'd2);
    run_job(2'd3);
    run_job(2'd0);
    run_job(2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
